// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant, binary index,
// hold-limit forced release and a rotating priority pointer.
module rr_arbiter_8 #(
  parameter int NREQ     = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] grant,
  output logic [2:0]      grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [7:0] hold_cnt;

  // First requester found when searching upward from the pointer, wrapping 7->0.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
    logic [2:0] k;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = p + 3'(i);
      if (!found && r[k]) begin
        rr_pick = k;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [2:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  logic [2:0] sel;
  logic       owner_req;
  logic       hold_hit;
  logic       release_now;

  assign sel         = rr_pick(req, ptr);
  assign owner_req   = req[grant_idx];
  assign hold_hit    = (hold_cnt == 8'(MAX_HOLD));
  assign release_now = done || !owner_req || hold_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      hold_cnt    <= 8'd0;
      grant       <= '0;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= onehot(sel);
            grant_idx   <= sel;
            grant_valid <= 1'b1;
            hold_cnt    <= 8'd1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= grant_idx + 3'd1;
            hold_cnt    <= 8'd0;
            state       <= IDLE;
            // Only a release caused purely by the hold limit is a timeout.
            timeout     <= !done && owner_req;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: reset, single requester, rotation,
// fairness, hold-limit timeout and reset during an active grant.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8 #(.NREQ(8), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                     input logic ev, input logic et);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {grant, grant_idx, grant_valid, timeout};
    exp = {eg, ei, ev, et};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed grant=%h idx=%0d gv=%b to=%b expected grant=%h idx=%0d gv=%b to=%b",
             tag, grant, grant_idx, grant_valid, timeout, eg, ei, ev, et);
    end
  endtask

  initial begin
    logic [2:0] e;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset and idle
    tick();
    tick();
    chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", 8'h00, 3'd0, 1'b0, 1'b0);
    end

    // Single requester 5, done on third grant cycle
    req = 8'h20;
    tick(); chk("single_c1", 8'h20, 3'd5, 1'b1, 1'b0);
    tick(); chk("single_c2", 8'h20, 3'd5, 1'b1, 1'b0);
    tick(); chk("single_c3", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    tick(); chk("single_rel", 8'h00, 3'd5, 1'b0, 1'b0);
    done = 1'b0;
    tick(); chk("single_regrant", 8'h20, 3'd5, 1'b1, 1'b0);
    req = 8'h00;
    tick(); chk("single_reqdrop", 8'h00, 3'd5, 1'b0, 1'b0);

    // Full rotation from pointer 0 with wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      e = 3'(k % 8);
      tick(); chk("rot_c1", 8'h01 << e, e, 1'b1, 1'b0);
      tick(); chk("rot_c2", 8'h01 << e, e, 1'b1, 1'b0);
      done = 1'b1;
      tick(); chk("rot_bubble", 8'h00, e, 1'b0, 1'b0);
      done = 1'b0;
    end
    req = 8'h00;
    tick();

    // Fairness between 0 and 7, done held high (ignored while idle)
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req  = 8'h81;
    done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 0) ? 3'd0 : 3'd7;
      tick(); chk("fair_grant", 8'h01 << e, e, 1'b1, 1'b0);
      tick(); chk("fair_bubble", 8'h00, e, 1'b0, 1'b0);
    end
    done = 1'b0;
    req  = 8'h00;
    tick();

    // Hold-limit timeout on requester 4
    req = 8'h10;
    for (int c = 1; c <= 16; c++) begin
      tick(); chk("hold", 8'h10, 3'd4, 1'b1, 1'b0);
    end
    tick(); chk("timeout_pulse", 8'h00, 3'd4, 1'b0, 1'b1);
    tick(); chk("timeout_regrant", 8'h10, 3'd4, 1'b1, 1'b0);
    for (int c = 2; c <= 16; c++) begin
      tick(); chk("hold2", 8'h10, 3'd4, 1'b1, 1'b0);
    end
    done = 1'b1;
    tick(); chk("done_at_limit", 8'h00, 3'd4, 1'b0, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    tick(); chk("idle_after", 8'h00, 3'd4, 1'b0, 1'b0);

    // Reset during a grant of requester 3 (pointer is 5 here)
    req = 8'h08;
    tick(); chk("pre_rst_grant", 8'h08, 3'd3, 1'b1, 1'b0);
    rst = 1'b1;
    req = 8'h09;
    tick(); chk("mid_rst", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); chk("post_rst_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
